// File: rtl/main.sv
// Order-entry FSM for the Diego's kiosk: steps a customer through type, dish,
// size, side and drink, registering each choice and holding the finished order.
module main (
  input  logic       clk,
  input  logic       reset,
  input  logic       PB1,
  input  logic       PB2,
  input  logic       PB3,
  input  logic [1:0] A,
  output logic       T2,
  output logic       Ac2,
  output logic       B2,
  output logic [1:0] Ta2,
  output logic [1:0] P2,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    INICIO    = 3'd0,
    TIPO      = 3'd1,
    PRINCIPAL = 3'd2,
    TAMANO    = 3'd3,
    ACOMP     = 3'd4,
    BEBIDA    = 3'd5,
    LISTO     = 3'd6
  } state_t;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       t2_d;
  logic       ac2_d;
  logic       b2_d;
  logic [1:0] ta2_d;
  logic [1:0] p2_d;

  // State register; order outputs are registered alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INICIO;
      T2      <= 1'b0;
      Ac2     <= 1'b0;
      B2      <= 1'b0;
      Ta2     <= 2'b00;
      P2      <= 2'b00;
    end else begin
      state_q <= state_d;
      T2      <= t2_d;
      Ac2     <= ac2_d;
      B2      <= b2_d;
      Ta2     <= ta2_d;
      P2      <= p2_d;
    end
  end

  // Next-state logic; cancel outranks every other input.
  always_comb begin
    state_d = state_q;
    if (PB3) begin
      state_d = INICIO;
    end else begin
      case (state_q)
        INICIO:    if (PB1) state_d = TIPO;
        TIPO:      if (PB1 || PB2) state_d = PRINCIPAL;
        PRINCIPAL: if (A != 2'b00) state_d = TAMANO;
        TAMANO:    if (A != 2'b00) state_d = ACOMP;
        ACOMP:     if (PB1 || PB2) state_d = BEBIDA;
        BEBIDA:    if (PB1 || PB2) state_d = LISTO;
        LISTO:     state_d = LISTO;
        default:   state_d = INICIO;
      endcase
    end
  end

  // Output logic: hold by default, capture the choice made in the current step.
  always_comb begin
    t2_d  = T2;
    ac2_d = Ac2;
    b2_d  = B2;
    ta2_d = Ta2;
    p2_d  = P2;
    if (PB3 || state_q == 3'd7) begin
      t2_d  = 1'b0;
      ac2_d = 1'b0;
      b2_d  = 1'b0;
      ta2_d = 2'b00;
      p2_d  = 2'b00;
    end else begin
      case (state_q)
        TIPO:      if (PB1 || PB2) t2_d = PB1;
        PRINCIPAL: if (A != 2'b00) p2_d = A;
        TAMANO:    if (A != 2'b00) ta2_d = A;
        ACOMP:     if (PB1 || PB2) ac2_d = PB1;
        BEBIDA:    if (PB1 || PB2) b2_d = PB1;
        default:   ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_main.sv
// Directed bench for the kiosk order FSM: one task per scenario, each comparing
// {state, T2, Ac2, B2, Ta2, P2} against hand-computed vectors.
module tb_main;

  logic       clk;
  logic       reset;
  logic       PB1, PB2, PB3;
  logic [1:0] A;
  logic       T2, Ac2, B2;
  logic [1:0] Ta2, P2;
  logic [2:0] state;
  logic [9:0] obs;

  int checks = 0;
  int passes = 0;

  main dut (
    .clk(clk), .reset(reset), .PB1(PB1), .PB2(PB2), .PB3(PB3), .A(A),
    .T2(T2), .Ac2(Ac2), .B2(B2), .Ta2(Ta2), .P2(P2), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {state, T2, Ac2, B2, Ta2, P2};

  // Apply one input set for exactly one rising edge, then return to idle.
  task automatic step(input logic p1, input logic p2, input logic p3, input logic [1:0] a);
    PB1 = p1; PB2 = p2; PB3 = p3; A = a;
    @(posedge clk);
    #1;
    PB1 = 1'b0; PB2 = 1'b0; PB3 = 1'b0; A = 2'b00;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    PB1 = 1'b0; PB2 = 1'b0; PB3 = 1'b0; A = 2'b00;
    reset = 1'b0;
    #2;
    checks++;
    if (obs !== 10'b000_0_0_0_00_00)
      $display("FAIL reset_state got=%b exp=%b", obs, 10'b000_0_0_0_00_00);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0, 2'b01);
    checks++;
    if (obs !== 10'b000_0_0_0_00_00)
      $display("FAIL inicio_ignores got=%b exp=%b", obs, 10'b000_0_0_0_00_00);
    else passes++;
  endtask

  task automatic test_combo();
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (obs !== 10'b001_0_0_0_00_00)
      $display("FAIL combo_tipo got=%b exp=%b", obs, 10'b001_0_0_0_00_00);
    else passes++;
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b01);
    checks++;
    if (obs !== 10'b011_1_0_0_00_01)
      $display("FAIL combo_dish got=%b exp=%b", obs, 10'b011_1_0_0_00_01);
    else passes++;
    step(1'b0, 1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (obs !== 10'b110_1_1_1_01_01)
      $display("FAIL combo_listo got=%b exp=%b", obs, 10'b110_1_1_1_01_01);
    else passes++;
    step(1'b0, 1'b1, 1'b0, 2'b10);
    checks++;
    if (obs !== 10'b110_1_1_1_01_01)
      $display("FAIL combo_hold got=%b exp=%b", obs, 10'b110_1_1_1_01_01);
    else passes++;
  endtask

  task automatic test_single();
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b10);
    step(1'b0, 1'b0, 1'b0, 2'b10);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    checks++;
    if (obs !== 10'b110_0_0_0_10_10)
      $display("FAIL single_listo got=%b exp=%b", obs, 10'b110_0_0_0_10_10);
    else passes++;
  endtask

  task automatic test_mixed();
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b00);
    checks++;
    if (obs !== 10'b010_1_0_0_00_00)
      $display("FAIL mixed_wait_dish got=%b exp=%b", obs, 10'b010_1_0_0_00_00);
    else passes++;
    step(1'b0, 1'b0, 1'b0, 2'b11);
    step(1'b0, 1'b0, 1'b0, 2'b10);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (obs !== 10'b110_1_0_1_10_11)
      $display("FAIL mixed_listo got=%b exp=%b", obs, 10'b110_1_0_1_10_11);
    else passes++;
  endtask

  task automatic test_cancel_dish();
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b01);
    checks++;
    if (obs !== 10'b011_0_0_0_00_01)
      $display("FAIL cancel_dish_pre got=%b exp=%b", obs, 10'b011_0_0_0_00_01);
    else passes++;
    step(1'b0, 1'b0, 1'b1, 2'b00);
    checks++;
    if (obs !== 10'b000_0_0_0_00_00)
      $display("FAIL cancel_dish got=%b exp=%b", obs, 10'b000_0_0_0_00_00);
    else passes++;
    step(1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b11);
    checks++;
    if (obs !== 10'b000_0_0_0_00_00)
      $display("FAIL cancel_dish_idle got=%b exp=%b", obs, 10'b000_0_0_0_00_00);
    else passes++;
  endtask

  task automatic test_cancel_acomp();
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b01);
    step(1'b0, 1'b0, 1'b0, 2'b10);
    step(1'b0, 1'b0, 1'b0, 2'b11);
    checks++;
    if (obs !== 10'b100_0_0_0_10_01)
      $display("FAIL acomp_ignores_a got=%b exp=%b", obs, 10'b100_0_0_0_10_01);
    else passes++;
    step(1'b1, 1'b0, 1'b1, 2'b00);
    checks++;
    if (obs !== 10'b000_0_0_0_00_00)
      $display("FAIL cancel_acomp got=%b exp=%b", obs, 10'b000_0_0_0_00_00);
    else passes++;
    step(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (obs !== 10'b001_0_0_0_00_00)
      $display("FAIL reenter_tipo got=%b exp=%b", obs, 10'b001_0_0_0_00_00);
    else passes++;
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    // PB1 held for three edges: one state per edge, then waits for a dish.
    PB1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== 10'b001_0_0_0_00_00)
      $display("FAIL held_edge1 got=%b exp=%b", obs, 10'b001_0_0_0_00_00);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (obs !== 10'b010_1_0_0_00_00)
      $display("FAIL held_edge2 got=%b exp=%b", obs, 10'b010_1_0_0_00_00);
    else passes++;
    @(posedge clk); #1;
    PB1 = 1'b0;
    checks++;
    if (obs !== 10'b010_1_0_0_00_00)
      $display("FAIL held_edge3 got=%b exp=%b", obs, 10'b010_1_0_0_00_00);
    else passes++;
    step(1'b0, 1'b0, 1'b0, 2'b11);
    step(1'b0, 1'b0, 1'b0, 2'b11);
    step(1'b1, 1'b1, 1'b0, 2'b00);
    checks++;
    if (obs !== 10'b101_1_1_0_11_11)
      $display("FAIL pb1_pb2_acomp got=%b exp=%b", obs, 10'b101_1_1_0_11_11);
    else passes++;
  endtask

  task automatic test_async_reset();
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b10);
    step(1'b0, 1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (obs !== 10'b101_1_1_0_01_10)
      $display("FAIL bebida_pre got=%b exp=%b", obs, 10'b101_1_1_0_01_10);
    else passes++;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 10'b000_0_0_0_00_00)
      $display("FAIL async_clear got=%b exp=%b", obs, 10'b000_0_0_0_00_00);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 1'b1, 2'b00);
    checks++;
    if (obs !== 10'b000_0_0_0_00_00)
      $display("FAIL cancel_beats_pb1 got=%b exp=%b", obs, 10'b000_0_0_0_00_00);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_combo();
    test_single();
    test_mixed();
    test_cancel_dish();
    test_cancel_acomp();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
